// File: rtl/alu_op_master.sv
// alu_op_master: requester-side companion to the 2-stage ALU.
// Accepts tagged requests, drives the ALU input port, tracks in-flight ops
// against the fixed ALU latency and buffers tagged results in a
// first-word-fall-through response FIFO. Request-side credits (occupancy)
// guarantee that a returning result always finds a free FIFO slot.
// Optional feature: define ALU_SCOREBOARD_EN to carry the operands through
// the tag pipe and flag results that differ from the expected value.
module alu_op_master #(
    parameter int DATA_WIDTH  = 8,
    parameter int SEL_WIDTH   = 2,
    parameter int TAG_WIDTH   = 2,
    parameter int RSP_DEPTH   = 4,
    parameter int ALU_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [DATA_WIDTH-1:0] req_a_i,
    input  logic [DATA_WIDTH-1:0] req_b_i,
    input  logic [SEL_WIDTH-1:0]  req_sel_i,
    input  logic [TAG_WIDTH-1:0]  req_tag_i,
    output logic                  alu_valid_o,
    output logic [DATA_WIDTH-1:0] alu_data_1_o,
    output logic [DATA_WIDTH-1:0] alu_data_2_o,
    output logic [SEL_WIDTH-1:0]  alu_sel_o,
    input  logic                  alu_valid_i,
    input  logic [DATA_WIDTH:0]   alu_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH:0]   rsp_data_o,
    output logic [TAG_WIDTH-1:0]  rsp_tag_o,
    output logic                  rsp_mismatch_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int RES_W  = DATA_WIDTH + 1;
    localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
    localparam int PIPE_D = ALU_LATENCY + 1;
    localparam logic [CNT_W-1:0] OCC_MAX = CNT_W'(RSP_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // Credit and handshake signals
    logic [CNT_W-1:0]     occ_r;
    logic                 accept_s;
    logic                 pop_s;
    logic                 push_s;

    // Issue register and in-flight tag pipe
    logic [TAG_WIDTH-1:0] iss_tag_r;
    logic [PIPE_D-1:0]    pv_r;
    logic [TAG_WIDTH-1:0] pt_r [PIPE_D];
    logic                 exp_s;
    logic [RES_W-1:0]     cap_data_s;

    // Response FIFO storage
    logic [RES_W-1:0]     mem_data_r [RSP_DEPTH];
    logic [TAG_WIDTH-1:0] mem_tag_r  [RSP_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 err_r;

    // Handshakes: ready is withheld during reset and when all credits are out
    assign req_ready_o = !rst && (occ_r < OCC_MAX);
    assign accept_s    = req_valid_i && req_ready_o;
    assign pop_s       = rsp_valid_o && rsp_ready_i;
    assign exp_s       = pv_r[PIPE_D-1];
    assign push_s      = exp_s;

    assign busy_o      = (occ_r != {CNT_W{1'b0}});
    assign rsp_valid_o = (cnt_r != {CNT_W{1'b0}});
    assign rsp_data_o  = mem_data_r[rd_ptr_r];
    assign rsp_tag_o   = mem_tag_r[rd_ptr_r];
    assign err_o       = err_r;

    // Credit counter: one credit per accepted op, returned when its response pops
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_r <= {CNT_W{1'b0}};
        end else if (accept_s && !pop_s) begin
            occ_r <= occ_r + CNT_ONE;
        end else if (!accept_s && pop_s) begin
            occ_r <= occ_r - CNT_ONE;
        end else begin
            occ_r <= occ_r;
        end
    end

    // ALU issue register: valid pulses per accept, operands hold their last values
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_valid_o  <= 1'b0;
            alu_data_1_o <= {DATA_WIDTH{1'b0}};
            alu_data_2_o <= {DATA_WIDTH{1'b0}};
            alu_sel_o    <= {SEL_WIDTH{1'b0}};
            iss_tag_r    <= {TAG_WIDTH{1'b0}};
        end else begin
            alu_valid_o <= accept_s;
            if (accept_s) begin
                alu_data_1_o <= req_a_i;
                alu_data_2_o <= req_b_i;
                alu_sel_o    <= req_sel_i;
                iss_tag_r    <= req_tag_i;
            end
        end
    end

    // Tag pipe fed from the issue register; its last stage lines up with alu_valid_i
    always_ff @(posedge clk) begin
        if (rst) begin
            pv_r <= {PIPE_D{1'b0}};
            for (int i = 0; i < PIPE_D; i++) begin
                pt_r[i] <= {TAG_WIDTH{1'b0}};
            end
        end else begin
            pv_r    <= {pv_r[PIPE_D-2:0], alu_valid_o};
            pt_r[0] <= iss_tag_r;
            for (int i = 1; i < PIPE_D; i++) begin
                pt_r[i] <= pt_r[i-1];
            end
        end
    end

    // Capture data: a missing ALU result is replaced by zero so the tag still returns
    always_comb begin
        cap_data_s = {RES_W{1'b0}};
        if (alu_valid_i) begin
            cap_data_s = alu_data_i;
        end else begin
            cap_data_s = {RES_W{1'b0}};
        end
    end

    // Sticky protocol error: result present without expectation or vice versa
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (exp_s != alu_valid_i) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Response FIFO: push on expected capture, pop on handshake, both allowed when full
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_data_r[i] <= {RES_W{1'b0}};
                mem_tag_r[i]  <= {TAG_WIDTH{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_data_r[wr_ptr_r] <= cap_data_s;
                mem_tag_r[wr_ptr_r]  <= pt_r[PIPE_D-1];
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_ONE;
                2'b01:   cnt_r <= cnt_r - CNT_ONE;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

`ifdef ALU_SCOREBOARD_EN
    // Expected ALU result, computed modulo 2^(DATA_WIDTH+1)
    function automatic logic [RES_W-1:0] alu_expect(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [SEL_WIDTH-1:0]  sel
    );
        logic [RES_W-1:0] r;
        case (sel)
            SEL_WIDTH'(2'b00): r = {1'b0, a} + {1'b0, b};
            SEL_WIDTH'(2'b01): r = {1'b0, a} - {1'b0, b};
            SEL_WIDTH'(2'b10): r = {1'b0, a} + {{DATA_WIDTH{1'b0}}, 1'b1};
            default:           r = {RES_W{1'b0}};
        endcase
        return r;
    endfunction

    logic [DATA_WIDTH-1:0] pa_r [PIPE_D];
    logic [DATA_WIDTH-1:0] pb_r [PIPE_D];
    logic [SEL_WIDTH-1:0]  ps_r [PIPE_D];
    logic                  mem_mm_r [RSP_DEPTH];
    logic                  cap_mm_s;

    // Operand pipe travelling alongside the tag pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_D; i++) begin
                pa_r[i] <= {DATA_WIDTH{1'b0}};
                pb_r[i] <= {DATA_WIDTH{1'b0}};
                ps_r[i] <= {SEL_WIDTH{1'b0}};
            end
        end else begin
            pa_r[0] <= alu_data_1_o;
            pb_r[0] <= alu_data_2_o;
            ps_r[0] <= alu_sel_o;
            for (int i = 1; i < PIPE_D; i++) begin
                pa_r[i] <= pa_r[i-1];
                pb_r[i] <= pb_r[i-1];
                ps_r[i] <= ps_r[i-1];
            end
        end
    end

    // Compare the captured result with the expected one
    always_comb begin
        cap_mm_s = 1'b0;
        if (cap_data_s != alu_expect(pa_r[PIPE_D-1], pb_r[PIPE_D-1], ps_r[PIPE_D-1])) begin
            cap_mm_s = 1'b1;
        end else begin
            cap_mm_s = 1'b0;
        end
    end

    // Mismatch flag storage, written alongside the FIFO data
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_mm_r[i] <= 1'b0;
            end
        end else if (push_s) begin
            mem_mm_r[wr_ptr_r] <= cap_mm_s;
        end
    end

    assign rsp_mismatch_o = mem_mm_r[rd_ptr_r];
`else
    assign rsp_mismatch_o = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_master.sv
// Testbench for alu_op_master with a behavioural ALU and a response scoreboard.
// Honours ALU_SCOREBOARD_EN for the expected mismatch flag.
`timescale 1ns/1ps
module tb_alu_op_master;

    localparam int DW    = 8;
    localparam int SW    = 2;
    localparam int TW    = 2;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;
`ifdef ALU_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [DW-1:0] req_a_i = '0;
    logic [DW-1:0] req_b_i = '0;
    logic [SW-1:0] req_sel_i = '0;
    logic [TW-1:0] req_tag_i = '0;
    logic          alu_valid_o;
    logic [DW-1:0] alu_data_1_o;
    logic [DW-1:0] alu_data_2_o;
    logic [SW-1:0] alu_sel_o;
    logic          alu_valid_i;
    logic [DW:0]   alu_data_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [DW:0]   rsp_data_o;
    logic [TW-1:0] rsp_tag_o;
    logic          rsp_mismatch_o;
    logic          busy_o;
    logic          err_o;

    always #5 clk = ~clk;

    alu_op_master dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_sel_i(req_sel_i), .req_tag_i(req_tag_i),
        .alu_valid_o(alu_valid_o), .alu_data_1_o(alu_data_1_o), .alu_data_2_o(alu_data_2_o),
        .alu_sel_o(alu_sel_o), .alu_valid_i(alu_valid_i), .alu_data_i(alu_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_tag_o(rsp_tag_o), .rsp_mismatch_o(rsp_mismatch_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    // Arithmetic rule of the ALU, modulo 512
    function automatic logic [DW:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [SW-1:0] sel);
        int r;
        case (sel)
            2'd0:    r = int'(a) + int'(b);
            2'd1:    r = int'(a) - int'(b) + 512;
            2'd2:    r = int'(a) + 1;
            default: r = 0;
        endcase
        return 9'(r % 512);
    endfunction

    // Behavioural ALU: samples its input, answers LAT edges later; no reset
    logic          corrupt = 1'b0;
    logic          inj = 1'b0;
    logic [LAT:0]  av = '0;
    logic [DW:0]   ad [LAT+1];
    always @(posedge clk) begin
        av[0] <= alu_valid_o;
        ad[0] <= corrupt ? 9'h055 : alu_fn(alu_data_1_o, alu_data_2_o, alu_sel_o);
        for (int i = 1; i <= LAT; i++) begin
            av[i] <= av[i-1];
            ad[i] <= ad[i-1];
        end
    end
    assign alu_valid_i = av[LAT] | inj;
    assign alu_data_i  = av[LAT] ? ad[LAT] : 9'h1AA;

    // Scoreboard state
    typedef struct {
        logic [DW:0]   data;
        logic [TW-1:0] tag;
        logic          mm;
    } rsp_t;
    rsp_t q[$];
    int   occ = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    logic last_acc = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: record handshakes before the edge, update the model after it
    task automatic step();
        logic r, acc, pop;
        logic [DW-1:0] ra, rb;
        logic [SW-1:0] rs;
        logic [TW-1:0] rt;
        rsp_t got, e;
        logic [DW:0] ev;
        r  = rst;
        acc = req_valid_i && req_ready_o;
        pop = rsp_valid_o && rsp_ready_i;
        ra = req_a_i; rb = req_b_i; rs = req_sel_i; rt = req_tag_i;
        got.data = rsp_data_o; got.tag = rsp_tag_o; got.mm = rsp_mismatch_o;
        @(posedge clk);
        #1;
        last_acc = acc && !r;
        if (r) begin
            q.delete();
            occ = 0;
        end else begin
            if (pop) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL pop_empty: got a response, expected none at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("rsp_data", 32'(got.data), 32'(e.data));
                    chk("rsp_tag", 32'(got.tag), 32'(e.tag));
                    chk("rsp_mm", 32'(got.mm), 32'(e.mm));
                end
                occ--;
            end
            if (acc) begin
                ev = alu_fn(ra, rb, rs);
                e.data = corrupt ? 9'h055 : ev;
                e.tag  = rt;
                e.mm   = SB && (e.data != ev);
                q.push_back(e);
                occ++;
            end
        end
        chk("req_ready", 32'(req_ready_o), 32'(!rst && occ < DEPTH));
        chk("busy", 32'(busy_o), 32'(occ != 0));
    endtask

    task automatic drain();
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        for (int c = 0; c < 40 && (q.size() != 0 || occ != 0); c++) step();
        chk("drain_left", 32'(q.size()), 32'd0);
    endtask

    task automatic wait_rsp(input string nm);
        for (int c = 0; c < 12 && !rsp_valid_o; c++) step();
        chk(nm, 32'(rsp_valid_o), 32'd1);
    endtask

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [SW-1:0] sel;
        logic [TW-1:0] tag;
        logic [DW:0]   exp;
    } vec_t;
    vec_t tbl [4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n_acc;
        int idx;
        tbl[0] = '{a: 8'd200, b: 8'd100, sel: 2'b00, tag: 2'd1, exp: 9'h12C};
        tbl[1] = '{a: 8'd5,   b: 8'd7,   sel: 2'b01, tag: 2'd0, exp: 9'h1FE};
        tbl[2] = '{a: 8'd255, b: 8'd0,   sel: 2'b10, tag: 2'd1, exp: 9'h100};
        tbl[3] = '{a: 8'h33,  b: 8'h44,  sel: 2'b11, tag: 2'd2, exp: 9'h000};

        // Reset state
        for (int i = 0; i < 3; i++) step();
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_alu_valid", 32'(alu_valid_o), 32'd0);
        chk("rst_alu_d1", 32'(alu_data_1_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data_o), 32'd0);
        chk("rst_rsp_tag", 32'(rsp_tag_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(req_ready_o), 32'd1);

        // Single request and its latency
        req_valid_i = 1'b1;
        req_a_i = tbl[0].a; req_b_i = tbl[0].b; req_sel_i = tbl[0].sel; req_tag_i = tbl[0].tag;
        step();
        req_valid_i = 1'b0;
        chk("t1_acc", 32'(last_acc), 32'd1);
        chk("t1_alu_valid", 32'(alu_valid_o), 32'd1);
        chk("t1_alu_d1", 32'(alu_data_1_o), 32'd200);
        chk("t1_alu_d2", 32'(alu_data_2_o), 32'd100);
        chk("t1_alu_sel", 32'(alu_sel_o), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 1) begin
                chk("t1_alu_pulse", 32'(alu_valid_o), 32'd0);
                chk("t1_alu_hold", 32'(alu_data_1_o), 32'd200);
            end
            chk("t1_latency", 32'(rsp_valid_o), 32'(k == 4));
        end
        chk("t1_err", 32'(err_o), 32'd0);

        // Back-to-back table entries, then collect all four in order
        for (int i = 1; i < 4; i++) begin
            req_valid_i = 1'b1;
            req_a_i = tbl[i].a; req_b_i = tbl[i].b; req_sel_i = tbl[i].sel; req_tag_i = tbl[i].tag;
            step();
            chk("t2_acc", 32'(last_acc), 32'd1);
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        idx = 0;
        for (int c = 0; c < 30 && idx < 4; c++) begin
            if (rsp_valid_o) begin
                chk("t2_data", 32'(rsp_data_o), 32'(tbl[idx].exp));
                chk("t2_tag", 32'(rsp_tag_o), 32'(tbl[idx].tag));
                idx++;
            end
            step();
        end
        chk("t2_count", 32'(idx), 32'd4);
        chk("t2_busy_low", 32'(busy_o), 32'd0);

        // Stalled consumer: exactly DEPTH accepts, then one per pop
        rsp_ready_i = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            req_valid_i = 1'b1;
            req_a_i = DW'($urandom); req_b_i = DW'($urandom);
            req_sel_i = SW'($urandom); req_tag_i = TW'(n_acc);
            step();
            if (last_acc) n_acc++;
        end
        chk("t3_accepts", 32'(n_acc), 32'd4);
        chk("t3_full_ready", 32'(req_ready_o), 32'd0);
        rsp_ready_i = 1'b1;
        for (int c = 0; c < 20 && n_acc < 6; c++) begin
            req_tag_i = TW'(n_acc);
            step();
            if (last_acc) n_acc++;
        end
        chk("t3_refill", 32'(n_acc), 32'd6);
        drain();

        // Random traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            req_valid_i = 1'($urandom_range(0, 1));
            req_a_i = DW'($urandom); req_b_i = DW'($urandom);
            req_sel_i = SW'($urandom); req_tag_i = TW'($urandom);
            rsp_ready_i = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();
        chk("rand_err", 32'(err_o), 32'd0);

        // Unexpected ALU result
        inj = 1'b1;
        step();
        inj = 1'b0;
        chk("t4_err", 32'(err_o), 32'd1);
        for (int i = 0; i < 5; i++) step();
        chk("t4_err_sticky", 32'(err_o), 32'd1);
        chk("t4_no_rsp", 32'(rsp_valid_o), 32'd0);

        // Reset with ops in flight
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid_i = 1'b1;
            req_a_i = DW'($urandom); req_b_i = DW'($urandom);
            req_sel_i = SW'($urandom); req_tag_i = TW'(i);
            step();
        end
        req_valid_i = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
        #1;
        chk("t5_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("t5_busy", 32'(busy_o), 32'd0);
        chk("t5_err", 32'(err_o), 32'd0);
        for (int i = 0; i < 4; i++) step();
        chk("t5_quiet", 32'(rsp_valid_o), 32'd0);
        chk("t5_err_quiet", 32'(err_o), 32'd0);
        req_valid_i = 1'b1;
        req_a_i = 8'd10; req_b_i = 8'd3; req_sel_i = 2'b01; req_tag_i = 2'd3;
        step();
        req_valid_i = 1'b0;
        wait_rsp("t5_wait");
        chk("t5_data", 32'(rsp_data_o), 32'h007);
        chk("t5_tag", 32'(rsp_tag_o), 32'd3);
        drain();

        // Corrupted ALU result
        corrupt = 1'b1;
        req_valid_i = 1'b1;
        req_a_i = 8'd200; req_b_i = 8'd100; req_sel_i = 2'b00; req_tag_i = 2'd2;
        rsp_ready_i = 1'b0;
        step();
        req_valid_i = 1'b0;
        wait_rsp("t6_wait");
        chk("t6_data", 32'(rsp_data_o), 32'h055);
        chk("t6_mismatch", 32'(rsp_mismatch_o), 32'(SB));
        chk("t6_err", 32'(err_o), 32'd0);
        drain();
        corrupt = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
